test_monitor: RTL and testbench

Synthesizable run-control and pass/fail monitor for the mini-rv core. It replaces fixed-delay waits and post-hoc register peeking with cycle-accurate end-of-test detection, which works in simulation and on FPGA. It observes the core's retire stream and data-memory write port, and detects three end-of-test conditions: a tohost write (riscv-tests convention), a self-loop hang and a cycle timeout. It reports a latched verdict and performance counters. It sits beside `core_top`, driven by taps on the core's retire and store signals, and has no influence on core behaviour.

---
 rtl/test_monitor.sv | 108 ++++++++++
 tb/tb_test_monitor.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/test_monitor.sv
// rtl/test_monitor.sv - end-of-test monitor for the mini-rv core
// Watches retire and store taps, latches a PASS/FAIL/TIMEOUT/HANG verdict and perf counters.
module test_monitor #(
  parameter int               XLEN           = 32,
  parameter int               CNT_W          = 32,
  parameter logic [XLEN-1:0]  TOHOST_ADDR    = 32'h0000_1000,
  parameter int               TIMEOUT_CYCLES = 100,
  parameter int               HANG_LIMIT     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             retire_valid,
  input  logic [XLEN-1:0]  retire_pc,
  input  logic             dmem_we,
  input  logic [XLEN-1:0]  dmem_addr,
  input  logic [XLEN-1:0]  dmem_wdata,
  output logic             done,
  output logic             pass,
  output logic [2:0]       status,
  output logic [XLEN-1:0]  fail_code,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instret_count
);

  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_PASS    = 3'd1,
    ST_FAIL    = 3'd2,
    ST_TIMEOUT = 3'd3,
    ST_HANG    = 3'd4
  } status_e;

  localparam int HW = $clog2(HANG_LIMIT + 1);

  status_e          status_q;
  logic             done_q;
  logic             pass_q;
  logic [XLEN-1:0]  fail_code_q;
  logic [CNT_W-1:0] cycle_q;
  logic [CNT_W-1:0] instret_q;
  logic [XLEN-1:0]  prev_pc_q;
  logic             prev_valid_q;
  logic [HW-1:0]    hang_q;

  logic [CNT_W-1:0] cycle_d;
  logic [CNT_W-1:0] instret_d;
  logic [HW-1:0]    hang_d;
  logic             same_pc;
  logic             tohost_hit;
  logic             hang_hit;
  logic             timeout_hit;

  // Counters saturate rather than wrap so a runaway test never reads as short.
  assign cycle_d     = (cycle_q == '1) ? cycle_q : cycle_q + CNT_W'(1);
  assign instret_d   = (instret_q == '1) ? instret_q : instret_q + CNT_W'(1);
  assign same_pc     = retire_valid && prev_valid_q && (retire_pc == prev_pc_q);
  assign hang_d      = hang_q + HW'(1);
  assign tohost_hit  = dmem_we && (dmem_addr == TOHOST_ADDR) && dmem_wdata[0];
  assign hang_hit    = same_pc && (hang_d == HW'(HANG_LIMIT));
  assign timeout_hit = (cycle_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      status_q     <= ST_RUN;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_code_q  <= '0;
      cycle_q      <= '0;
      instret_q    <= '0;
      prev_pc_q    <= '0;
      prev_valid_q <= 1'b0;
      hang_q       <= '0;
    end else if (status_q == ST_RUN) begin
      cycle_q <= cycle_d;
      if (retire_valid) begin
        instret_q    <= instret_d;
        prev_pc_q    <= retire_pc;
        prev_valid_q <= 1'b1;
        hang_q       <= same_pc ? hang_d : '0;
      end
      // Even tohost stores are progress markers, not verdicts, so only odd data ends the test.
      if (tohost_hit) begin
        done_q <= 1'b1;
        if (dmem_wdata == XLEN'(1)) begin
          status_q <= ST_PASS;
          pass_q   <= 1'b1;
        end else begin
          status_q    <= ST_FAIL;
          fail_code_q <= dmem_wdata >> 1;
        end
      end else if (hang_hit) begin
        status_q <= ST_HANG;
        done_q   <= 1'b1;
      end else if (timeout_hit) begin
        status_q <= ST_TIMEOUT;
        done_q   <= 1'b1;
      end
    end
  end

  assign done          = done_q;
  assign pass          = pass_q;
  assign status        = status_q;
  assign fail_code     = fail_code_q;
  assign cycle_count   = cycle_q;
  assign instret_count = instret_q;

endmodule

// File: tb/tb_test_monitor.sv
// tb/tb_test_monitor.sv - directed bench for test_monitor
// Table-driven program run plus hand-written fail, hang, timeout, priority and reset sequences.
module tb_test_monitor;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        retire_valid = 1'b0;
  logic [31:0] retire_pc = '0;
  logic        dmem_we = 1'b0;
  logic [31:0] dmem_addr = '0;
  logic [31:0] dmem_wdata = '0;
  logic        done;
  logic        pass;
  logic [2:0]  status;
  logic [31:0] fail_code;
  logic [31:0] cycle_count;
  logic [31:0] instret_count;

  int errors = 0;
  int checks = 0;

  test_monitor dut (
    .clk           (clk),
    .reset         (reset),
    .retire_valid  (retire_valid),
    .retire_pc     (retire_pc),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_wdata    (dmem_wdata),
    .done          (done),
    .pass          (pass),
    .status        (status),
    .fail_code     (fail_code),
    .cycle_count   (cycle_count),
    .instret_count (instret_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rv;
    logic [31:0] pc;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [2:0]  st;
    logic [31:0] cyc;
    logic [31:0] inst;
    logic [31:0] fc;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [2:0] st, input logic [31:0] cyc,
                            input logic [31:0] inst, input logic [31:0] fc);
    chk({tag, " status"}, 64'(status), 64'(st));
    chk({tag, " done"}, 64'(done), 64'(st != 3'd0));
    chk({tag, " pass"}, 64'(pass), 64'(st == 3'd1));
    chk({tag, " cycle"}, 64'(cycle_count), 64'(cyc));
    chk({tag, " instret"}, 64'(instret_count), 64'(inst));
    chk({tag, " fail_code"}, 64'(fail_code), 64'(fc));
  endtask

  // Called at a falling edge; checks the asynchronous clear before any rising edge.
  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1;
    expect_out({tag, " async reset"}, 3'd0, 32'd0, 32'd0, 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic step(input logic rv, input logic [31:0] pc, input logic we,
                      input logic [31:0] a, input logic [31:0] wd);
    retire_valid = rv;
    retire_pc    = pc;
    dmem_we      = we;
    dmem_addr    = a;
    dmem_wdata   = wd;
    @(posedge clk);
    @(negedge clk);
    retire_valid = 1'b0;
    dmem_we      = 1'b0;
  endtask

  initial begin
    //          rv    pc      we    addr      wd     st    cyc  inst  fc
    tbl[0] = '{1'b1, 32'h00, 1'b0, 32'h0,    32'd0, 3'd0, 32'd1, 32'd1, 32'd0};
    tbl[1] = '{1'b1, 32'h04, 1'b1, 32'h1000, 32'd2, 3'd0, 32'd2, 32'd2, 32'd0};
    tbl[2] = '{1'b1, 32'h08, 1'b1, 32'h1004, 32'd1, 3'd0, 32'd3, 32'd3, 32'd0};
    tbl[3] = '{1'b1, 32'h0c, 1'b1, 32'h1000, 32'd0, 3'd0, 32'd4, 32'd4, 32'd0};
    tbl[4] = '{1'b1, 32'h10, 1'b0, 32'h0,    32'd0, 3'd0, 32'd5, 32'd5, 32'd0};
    tbl[5] = '{1'b1, 32'h14, 1'b0, 32'h0,    32'd0, 3'd0, 32'd6, 32'd6, 32'd0};
    tbl[6] = '{1'b1, 32'h18, 1'b0, 32'h0,    32'd0, 3'd0, 32'd7, 32'd7, 32'd0};
    tbl[7] = '{1'b1, 32'h1c, 1'b0, 32'h0,    32'd0, 3'd0, 32'd8, 32'd8, 32'd0};
    tbl[8] = '{1'b1, 32'h20, 1'b1, 32'h1000, 32'd1, 3'd1, 32'd9, 32'd9, 32'd0};
    tbl[9] = '{1'b1, 32'h24, 1'b1, 32'h1000, 32'd3, 3'd1, 32'd9, 32'd9, 32'd0};

    @(negedge clk);
    do_reset("init");

    for (int i = 0; i < 10; i++) begin
      step(tbl[i].rv, tbl[i].pc, tbl[i].we, tbl[i].addr, tbl[i].wd);
      expect_out($sformatf("prog row %0d", i), tbl[i].st, tbl[i].cyc, tbl[i].inst, tbl[i].fc);
    end

    // Reset from a terminal PASS state, then counting restarts at 1.
    do_reset("from pass");
    step(1'b0, 32'h0, 1'b0, 32'h0, 32'd0);
    expect_out("after pass reset", 3'd0, 32'd1, 32'd0, 32'd0);

    // FAIL verdict and its freeze.
    do_reset("fail");
    for (int k = 1; k <= 4; k++) step(1'b0, 32'h0, 1'b0, 32'h0, 32'd0);
    step(1'b0, 32'h0, 1'b1, 32'h1000, 32'h7);
    expect_out("fail edge5", 3'd2, 32'd5, 32'd0, 32'd3);
    step(1'b1, 32'h40, 1'b1, 32'h1000, 32'h1);
    expect_out("fail frozen", 3'd2, 32'd5, 32'd0, 32'd3);

    // Self-loop at 0x18 from edge 3 hangs after edge 7.
    do_reset("hang");
    step(1'b1, 32'h10, 1'b0, 32'h0, 32'd0);
    step(1'b1, 32'h14, 1'b0, 32'h0, 32'd0);
    for (int k = 3; k <= 6; k++) step(1'b1, 32'h18, 1'b0, 32'h0, 32'd0);
    expect_out("hang edge6", 3'd0, 32'd6, 32'd6, 32'd0);
    step(1'b1, 32'h18, 1'b0, 32'h0, 32'd0);
    expect_out("hang edge7", 3'd4, 32'd7, 32'd7, 32'd0);
    step(1'b1, 32'h18, 1'b1, 32'h1000, 32'd1);
    expect_out("hang frozen", 3'd4, 32'd7, 32'd7, 32'd0);

    // An interleaved retire at 0x14 restarts the count.
    do_reset("hang break");
    for (int k = 1; k <= 3; k++) step(1'b1, 32'h18, 1'b0, 32'h0, 32'd0);
    step(1'b1, 32'h14, 1'b0, 32'h0, 32'd0);
    for (int k = 5; k <= 8; k++) step(1'b1, 32'h18, 1'b0, 32'h0, 32'd0);
    expect_out("hang break edge8", 3'd0, 32'd8, 32'd8, 32'd0);
    step(1'b1, 32'h18, 1'b0, 32'h0, 32'd0);
    expect_out("hang break edge9", 3'd4, 32'd9, 32'd9, 32'd0);

    // A retire-free cycle keeps the hang count.
    do_reset("hang gap");
    for (int k = 1; k <= 3; k++) step(1'b1, 32'h18, 1'b0, 32'h0, 32'd0);
    step(1'b0, 32'h0, 1'b0, 32'h0, 32'd0);
    step(1'b1, 32'h18, 1'b0, 32'h0, 32'd0);
    expect_out("hang gap edge5", 3'd0, 32'd5, 32'd4, 32'd0);
    step(1'b1, 32'h18, 1'b0, 32'h0, 32'd0);
    expect_out("hang gap edge6", 3'd4, 32'd6, 32'd5, 32'd0);

    // Timeout after edge 100, then frozen.
    do_reset("timeout");
    for (int k = 1; k <= 99; k++) step(1'b1, 32'(4 * k), 1'b0, 32'h0, 32'd0);
    expect_out("timeout edge99", 3'd0, 32'd99, 32'd99, 32'd0);
    step(1'b1, 32'd400, 1'b0, 32'h0, 32'd0);
    expect_out("timeout edge100", 3'd3, 32'd100, 32'd100, 32'd0);
    for (int k = 0; k < 5; k++) step(1'b1, 32'h500, 1'b1, 32'h1000, 32'd1);
    expect_out("timeout frozen", 3'd3, 32'd100, 32'd100, 32'd0);

    // Tohost, hang and timeout all on edge 100: PASS wins; without the store HANG wins.
    for (int run = 0; run < 2; run++) begin
      do_reset($sformatf("prio%0d", run));
      for (int k = 1; k <= 99; k++)
        step(1'b1, (k < 96) ? 32'(4 * k) : 32'h400, 1'b0, 32'h0, 32'd0);
      expect_out($sformatf("prio%0d edge99", run), 3'd0, 32'd99, 32'd99, 32'd0);
      step(1'b1, 32'h400, (run == 0), 32'h1000, 32'd1);
      expect_out($sformatf("prio%0d edge100", run), (run == 0) ? 3'd1 : 3'd4,
                 32'd100, 32'd100, 32'd0);
    end

    // Reset mid-run at cycle 40.
    do_reset("midrun");
    for (int k = 1; k <= 40; k++) step(1'b1, 32'(8 * k), 1'b0, 32'h0, 32'd0);
    expect_out("midrun edge40", 3'd0, 32'd40, 32'd40, 32'd0);
    do_reset("midrun");
    step(1'b1, 32'h0, 1'b0, 32'h0, 32'd0);
    expect_out("midrun restart", 3'd0, 32'd1, 32'd1, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
